// File: rtl/lcd_key_ctrl.sv
// lcd_key_ctrl
//   Conditions the raw active-low board keys for the character-display stage
//   and keeps the display selection state (character and colour index).
//   Ports:
//     lcd_clk    pixel clock, all logic on the rising edge
//     sys_rst    asynchronous active-high reset
//     key        raw keys, active-low, asynchronous to lcd_clk
//     key_level  debounced level, 1 = pressed
//     key_press  one-cycle pulse on each debounced press
//     char_sel   selected character index, 0..CHAR_NUM-1
//     color_sel  selected colour index, 0..3

// lcd_key_lane
//   One key: two-flop synchroniser, debounce counter and press pulse.
//   Ports:
//     lcd_clk, sys_rst  clock and async reset
//     key               raw key, active-low
//     level             debounced level, 1 = pressed
//     press             one-cycle pulse on a debounced press
module lcd_key_lane #(
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 666666
) (
  input  logic lcd_clk,
  input  logic sys_rst,
  input  logic key,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1, s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // s2 has differed from stable for a full debounce window
  assign accept = (s2 != stable) && (cnt == CNT_MAX);

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= accept && !s2;  // pulse only on released -> pressed
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = ~stable;

endmodule

module lcd_key_ctrl #(
  parameter int KEY_W        = 4,
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 666666,
  parameter int CHAR_NUM     = 8,
  parameter int SEL_W        = 3
) (
  input  logic             lcd_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [SEL_W-1:0] char_sel,
  output logic [1:0]       color_sel
);

  localparam logic [SEL_W-1:0] CHAR_MAX = SEL_W'(CHAR_NUM - 1);

  for (genvar i = 0; i < KEY_W; i++) begin : g_lane
    lcd_key_lane #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_lane (
      .lcd_clk (lcd_clk),
      .sys_rst (sys_rst),
      .key     (key[i]),
      .level   (key_level[i]),
      .press   (key_press[i])
    );
  end

  // key 3 clears both selections and wins over everything else;
  // keys 0/1 step the character (cancelling when both fire);
  // key 2 steps the colour independently of keys 0/1.
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      char_sel  <= '0;
      color_sel <= '0;
    end else if (key_press[3]) begin
      char_sel  <= '0;
      color_sel <= '0;
    end else begin
      if (key_press[0] && !key_press[1]) begin
        char_sel <= (char_sel == CHAR_MAX) ? '0 : char_sel + 1'b1;
      end else if (key_press[1] && !key_press[0]) begin
        char_sel <= (char_sel == '0) ? CHAR_MAX : char_sel - 1'b1;
      end
      if (key_press[2]) begin
        color_sel <= color_sel + 2'd1;
      end
    end
  end

endmodule
